// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer
//  Description : Iterative multiply/divide controller. Runs a WIDTH-cycle
//                shift/add multiplier or restoring divider, owns HI/LO and
//                requests an ID stall while an operation is in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_hilo,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_a_raw;    // original dividend, returned in HI on divide-by-zero
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dbz;

    // Operand magnitudes: op[0]==0 selects the signed variants (MULT, DIV)
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    assign w_signed = ~op[0];
    assign w_a_mag  = (w_signed & a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed & b[WIDTH-1]) ? -b : b;

    // One multiply step: conditional add into the upper half, then shift right with carry
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One restoring divide step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    // Sign correction applied in the FIX cycle
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    assign busy      = (r_state != S_IDLE);
    assign stall_req = use_hilo & ((r_state == S_CALC) | (r_state == S_FIX));

    // Sequencer FSM, datapath iteration and HI/LO ownership
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_a_raw   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    // MT writes land now; a result started this edge overwrites them later
                    if (hilo_we[1]) hi <= hilo_wdata;
                    if (hilo_we[0]) lo <= hilo_wdata;
                    if (start) begin
                        r_is_div  <= op[1];
                        r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= w_signed & a[WIDTH-1];
                        r_dbz     <= op[1] & (b == '0);
                        r_a_raw   <= a;
                        r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
                        r_cnt     <= '0;
                        r_state   <= S_CALC;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        // Divide-by-zero result overrides the sign rules
                        hi <= r_dbz ? r_a_raw : w_rem_fix;
                        lo <= r_dbz ? '1 : w_quo_fix;
                    end else begin
                        {hi, lo} <= w_prod_fix;
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sequencer
//  Description : Scoreboard bench for mdu_sequencer against an arithmetic
//                reference model (directed corner cases plus random ops).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_sequencer;

    localparam int W   = 32;
    localparam int LAT = 33;   // done visible after the 33rd edge following the start edge

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          use_hilo = 1'b0;
    logic [1:0]    hilo_we = 2'b00;
    logic [W-1:0]  hilo_wdata = '0;
    logic          busy;
    logic          done;
    logic          stall_req;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   exp_q[$];
    logic [31:0]   m_hi = '0;
    logic [31:0]   m_lo = '0;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .use_hilo   (use_hilo),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .done       (done),
        .stall_req  (stall_req),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: returns {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx;
        int          sy;
        longint      p;
        longint unsigned pu;
        logic [31:0] q;
        logic [31:0] r;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin p = longint'(sx) * longint'(sy); return p; end
            2'd1: begin pu = {32'd0, x} * {32'd0, y}; return pu; end
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = x / y;
                r = x % y;
                return {r, q};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_hilo", {hi, lo}, e);
                end
            end
        end
    end

    // Issue one op and watch busy/done/stall timing; optional MT writes at start or mid-CALC
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic uh, input int mt_cycle, input logic mt_with_start);
        logic [63:0] e;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          done_k;
        int          busy_cnt;
        e = model(o, x, y);
        @(negedge clock);
        op = o; a = x; b = y; use_hilo = uh; start = 1'b1;
        if (mt_with_start) begin
            hilo_we = 2'b11; hilo_wdata = 32'h0000_1234;
            m_hi = 32'h0000_1234; m_lo = 32'h0000_1234;
        end
        exp_q.push_back(e);
        pre_hi = m_hi; pre_lo = m_lo;
        done_k = -1; busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (k == 0) begin
                start = 1'b0; hilo_we = 2'b00;
                if (mt_with_start) chk("mt_with_start", {hi, lo}, {32'h1234, 32'h1234});
            end
            if (k == mt_cycle) begin hilo_we = 2'b11; hilo_wdata = 32'hDEAD_BEEF; end
            if (k == mt_cycle + 1) begin
                hilo_we = 2'b00;
                chk("mt_in_calc_ignored", {hi, lo}, {pre_hi, pre_lo});
            end
            chk("stall_req", {63'd0, stall_req}, {63'd0, (uh && k < LAT)});
            if (busy) busy_cnt++;
            if (done && done_k < 0) done_k = k;
            if (!busy) break;
        end
        chk("done_latency", 64'(done_k), 64'(LAT));
        chk("busy_cycles", 64'(busy_cnt), 64'(LAT + 1));
        m_hi = e[63:32]; m_lo = e[31:0];
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        use_hilo = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_state", {hi, lo}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, stall_req}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // IDLE MT write
        hilo_we = 2'b11; hilo_wdata = 32'h0000_1234;
        @(negedge clock);
        hilo_we = 2'b00;
        chk("mt_idle", {hi, lo}, {32'h1234, 32'h1234});
        m_hi = 32'h1234; m_lo = 32'h1234;

        // Directed corners (mid-CALC MT strobe ignored)
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 1'b0);
        chk("multu_max", {m_hi, m_lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, -5, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, -5, 1'b0);
        run_op(2'd3, 32'd5, 32'd0, 1'b0, -5, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 1'b1);
        run_op(2'd2, 32'd9, 32'd0, 1'b0, -5, 1'b0);

        // Randomized ops
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: begin rx = 32'($urandom_range(0, 300)); ry = 32'($urandom_range(1, 20)); end
                3: ry = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, rx, ry, 1'($urandom_range(0, 1)), -5, 1'b0);
        end

        // Reset while counter is 10: op abandoned, no done pulse
        @(negedge clock);
        op = 2'd3; a = 32'd1000; b = 32'd3; use_hilo = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_flags", {61'd0, busy, done, stall_req}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        chk("idle_after_reset", {63'd0, busy}, 64'd0);

        run_op(2'd3, 32'd100, 32'd7, 1'b0, -5, 1'b0);
        chk("divu_after_reset", {m_hi, m_lo}, {32'd2, 32'd14});

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
